mem_arbiter: RTL and testbench

- Shares the single external line-memory port between the instruction cache and the data cache.
- Data-cache requests are line refills (read) or line write-backs (write); instruction-cache requests are refills only.
- Two-way round-robin grant; one outstanding memory transaction at a time.
- Includes a wait-cycle watchdog so a hung memory cannot lock up either cache.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 24 ++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_LINE_W = 128;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between icache and dcache; purely combinational.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_valid = req_ic | req_dc;
        if (req_ic && req_dc) begin
            grant_id = ~last_grant;
        end else if (req_dc) begin
            grant_id = REQ_DC;
        end else begin
            grant_id = REQ_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-memory port between icache refills and dcache refills/write-backs,
// one transaction at a time, with a wait-cycle watchdog against a hung memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              dc_rqst_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              ic_ready_o,
    output logic              dc_ready_o,
    output logic [LINE_W-1:0] resp_data_o,
    output logic [ADDR_W-1:0] resp_addr_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_rqst_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

    arb_state_e        state_r, state_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic              grant_id_r, grant_id_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              grant_valid_s, grant_pick_s;
    logic              ic_ready_nxt_s, dc_ready_nxt_s, err_nxt_s, mem_rqst_nxt_s, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s, resp_addr_nxt_s;
    logic [LINE_W-1:0] mem_wdata_nxt_s, resp_data_nxt_s;

    arb_rr2 u_rr (
        .req_ic      (ic_rqst_i),
        .req_dc      (dc_rqst_i),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_pick_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus next value of every registered output and latch.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        grant_id_nxt_s   = grant_id_r;
        cnt_nxt_s        = cnt_r;
        mem_rqst_nxt_s   = 1'b0;
        mem_we_nxt_s     = mem_we_o;
        mem_addr_nxt_s   = mem_addr_o;
        mem_wdata_nxt_s  = mem_wdata_o;
        resp_data_nxt_s  = resp_data_o;
        resp_addr_nxt_s  = resp_addr_o;
        err_nxt_s        = 1'b0;
        ic_ready_nxt_s   = 1'b0;
        dc_ready_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_nxt_s      = ISSUE;
                    last_grant_nxt_s = grant_pick_s;
                    grant_id_nxt_s   = grant_pick_s;
                    mem_rqst_nxt_s   = 1'b1;
                    if (grant_pick_s == REQ_DC) begin
                        mem_addr_nxt_s = dc_addr_i;
                        mem_we_nxt_s   = dc_we_i;
                        if (dc_we_i) begin
                            mem_wdata_nxt_s = dc_wdata_i;
                        end else begin
                            mem_wdata_nxt_s = mem_wdata_o;
                        end
                    end else begin
                        mem_addr_nxt_s = ic_addr_i;
                        mem_we_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            WAIT: begin
                // A completion arriving on the timeout cycle still counts as a normal completion.
                if (mem_ready_i) begin
                    state_nxt_s     = RESP;
                    resp_addr_nxt_s = mem_addr_o;
                    if (!mem_we_o) begin
                        resp_data_nxt_s = mem_data_i;
                    end else begin
                        resp_data_nxt_s = resp_data_o;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = RESP;
                    resp_addr_nxt_s = mem_addr_o;
                    err_nxt_s       = 1'b1;
                end else if (cnt_r != CNT_SAT) begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if ((state_r == WAIT) && (state_nxt_s == RESP)) begin
            ic_ready_nxt_s = (grant_id_r == REQ_IC);
            dc_ready_nxt_s = (grant_id_r == REQ_DC);
        end else begin
            ic_ready_nxt_s = 1'b0;
            dc_ready_nxt_s = 1'b0;
        end
    end

    // Registered outputs, grant bookkeeping and the wait counter.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            last_grant_r <= REQ_IC;
            grant_id_r   <= REQ_IC;
            cnt_r        <= {CNT_W{1'b0}};
            ic_ready_o   <= 1'b0;
            dc_ready_o   <= 1'b0;
            resp_data_o  <= {LINE_W{1'b0}};
            resp_addr_o  <= {ADDR_W{1'b0}};
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            mem_rqst_o   <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= {ADDR_W{1'b0}};
            mem_wdata_o  <= {LINE_W{1'b0}};
        end else begin
            last_grant_r <= last_grant_nxt_s;
            grant_id_r   <= grant_id_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ic_ready_o   <= ic_ready_nxt_s;
            dc_ready_o   <= dc_ready_nxt_s;
            resp_data_o  <= resp_data_nxt_s;
            resp_addr_o  <= resp_addr_nxt_s;
            err_o        <= err_nxt_s;
            busy_o       <= (state_nxt_s != IDLE);
            mem_rqst_o   <= mem_rqst_nxt_s;
            mem_we_o     <= mem_we_nxt_s;
            mem_addr_o   <= mem_addr_nxt_s;
            mem_wdata_o  <= mem_wdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 20;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rsn_i;
    logic          ic_rqst_i, dc_rqst_i, dc_we_i, mem_ready_i;
    logic [AW-1:0] ic_addr_i, dc_addr_i;
    logic [LW-1:0] dc_wdata_i, mem_data_i;
    logic          ic_ready_o, dc_ready_o, err_o, busy_o, mem_rqst_o, mem_we_o;
    logic [LW-1:0] resp_data_o, mem_wdata_o;
    logic [AW-1:0] resp_addr_o, mem_addr_o;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .ic_rqst_i(ic_rqst_i), .ic_addr_i(ic_addr_i),
        .dc_rqst_i(dc_rqst_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .ic_ready_o(ic_ready_o), .dc_ready_o(dc_ready_o),
        .resp_data_o(resp_data_o), .resp_addr_o(resp_addr_o),
        .err_o(err_o), .busy_o(busy_o),
        .mem_rqst_o(mem_rqst_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model state: who won last, what the response/write registers should hold.
    logic          m_last;
    logic [LW-1:0] m_resp_data;
    logic [LW-1:0] m_wdata;
    int            last_strobe;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, LW'({ic_ready_o, dc_ready_o, err_o, busy_o, mem_rqst_o, mem_we_o}), '0);
        check_eq({tag, "_maddr"}, LW'(mem_addr_o), '0);
        check_eq({tag, "_raddr"}, LW'(resp_addr_o), '0);
        check_eq({tag, "_rdata"}, resp_data_o, '0);
        check_eq({tag, "_wdata"}, mem_wdata_o, '0);
    endtask

    task automatic model_reset();
        m_last      = REQ_IC;
        m_resp_data = '0;
        m_wdata     = '0;
        last_strobe = -1;
    endtask

    task automatic do_reset();
        rsn_i = 1'b0;
        ic_rqst_i = 1'b0; dc_rqst_i = 1'b0; dc_we_i = 1'b0; mem_ready_i = 1'b0;
        ic_addr_i = '0; dc_addr_i = '0; dc_wdata_i = '0; mem_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        model_reset();
    endtask

    // One arbitration round starting in an IDLE cycle; lat = cycles from strobe to memory
    // answer (<=0 means the memory never answers). Returns in the following IDLE cycle.
    task automatic run_txn(input int lat, input bit drop, input logic [LW-1:0] rdata);
        logic          win, w_we, early;
        logic [AW-1:0] w_addr;
        int            er;
        if (ic_rqst_i && dc_rqst_i) win = ~m_last;
        else if (dc_rqst_i)         win = REQ_DC;
        else                        win = REQ_IC;
        if (win == REQ_DC) begin
            w_addr = dc_addr_i; w_we = dc_we_i;
            if (dc_we_i) m_wdata = dc_wdata_i;
        end else begin
            w_addr = ic_addr_i; w_we = 1'b0;
        end
        m_last = win;
        check_eq("idle_before", LW'({busy_o, mem_rqst_o}), '0);
        step();
        check_eq("strobe", LW'({mem_rqst_o, busy_o}), LW'(2'b11));
        check_eq("mem_we", LW'(mem_we_o), LW'(w_we));
        check_eq("mem_addr", LW'(mem_addr_o), LW'(w_addr));
        check_eq("mem_wdata", mem_wdata_o, m_wdata);
        if (last_strobe >= 0) check_eq("strobe_gap_ge4", LW'(cyc - last_strobe >= 4), LW'(1'b1));
        last_strobe = cyc;
        if (drop) begin
            if (win == REQ_DC) begin
                dc_rqst_i = 1'b0; dc_addr_i = AW'($urandom); dc_we_i = ~dc_we_i;
                dc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                ic_rqst_i = 1'b0; ic_addr_i = AW'($urandom);
            end
        end
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_data_i  = {$urandom, $urandom, $urandom, $urandom};
        er    = (lat > 0) ? 2 + lat : 2 + TO;
        early = 1'b0;
        for (int c = 2; c <= er; c++) begin
            step();
            mem_ready_i = 1'b0;
            mem_data_i  = {$urandom, $urandom, $urandom, $urandom};
            if (c < er) begin
                if (ic_ready_o || dc_ready_o || mem_rqst_o || err_o || !busy_o) early = 1'b1;
                if (lat > 0 && c == 1 + lat) begin
                    mem_ready_i = 1'b1;
                    mem_data_i  = rdata;
                end
            end
        end
        if (lat > 0 && !w_we) m_resp_data = rdata;
        check_eq("quiet_until_ready", LW'(early), '0);
        check_eq("ic_ready", LW'(ic_ready_o), LW'(win == REQ_IC));
        check_eq("dc_ready", LW'(dc_ready_o), LW'(win == REQ_DC));
        check_eq("err", LW'(err_o), LW'(lat <= 0));
        check_eq("resp_data", resp_data_o, m_resp_data);
        if (lat > 0) check_eq("resp_addr", LW'(resp_addr_o), LW'(w_addr));
        if (win == REQ_DC) dc_rqst_i = 1'b0;
        else               ic_rqst_i = 1'b0;
        mem_ready_i = 1'($urandom_range(0, 1));
        step();
        mem_ready_i = 1'b0;
        check_eq("back_idle", LW'({ic_ready_o, dc_ready_o, err_o, busy_o}), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        do_reset();
        check_all_zero("reset");

        // IC-only refill, memory answers at cycle 4
        ic_rqst_i = 1'b1; ic_addr_i = 20'h12340;
        run_txn(3, 1'b0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

        // Both requesting permanently after reset: DC, IC, DC, IC
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ic_rqst_i = 1'b1; ic_addr_i = AW'(20'h01000 + i);
            dc_rqst_i = 1'b1; dc_addr_i = AW'(20'h02000 + i); dc_we_i = 1'b0;
            run_txn(1, 1'b0, {4{$urandom}});
        end

        // DC write-back keeps the previous read data on resp_data_o
        dc_rqst_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 20'h0ABC0; dc_wdata_i = {32{4'h1}};
        run_txn(2, 1'b0, {4{$urandom}});

        // Timeout, then a late answer that must be ignored
        ic_rqst_i = 1'b1; ic_addr_i = 20'h33330;
        run_txn(-1, 1'b0, '0);
        step();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        check_eq("late_ready_ignored", LW'({ic_ready_o, dc_ready_o, err_o, busy_o}), '0);
        step();
        check_eq("late_ready_idle", LW'({ic_ready_o, dc_ready_o, busy_o}), '0);

        // Asynchronous reset in the middle of WAIT
        ic_rqst_i = 1'b1; ic_addr_i = 20'h44440;
        repeat (3) step();
        check_eq("in_wait_busy", LW'(busy_o), LW'(1'b1));
        #3;
        rsn_i = 1'b0;
        ic_rqst_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        model_reset();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        check_eq("post_reset_ignored", LW'({ic_ready_o, dc_ready_o, busy_o, mem_rqst_o}), '0);
        ic_rqst_i = 1'b1; ic_addr_i = 20'h55550;
        dc_rqst_i = 1'b1; dc_addr_i = 20'h66660; dc_we_i = 1'b0;
        run_txn(2, 1'b0, {4{$urandom}});
        run_txn(1, 1'b0, {4{$urandom}});

        // Spurious memory ready in IDLE, then a withdrawn IC request
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        check_eq("spurious_idle", LW'({ic_ready_o, dc_ready_o, busy_o, mem_rqst_o}), '0);
        ic_rqst_i = 1'b1; ic_addr_i = 20'h77770;
        run_txn(4, 1'b1, {4{$urandom}});

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!ic_rqst_i && $urandom_range(0, 1) == 1) begin
                ic_rqst_i = 1'b1; ic_addr_i = AW'($urandom);
            end
            if (!dc_rqst_i && $urandom_range(0, 1) == 1) begin
                dc_rqst_i = 1'b1; dc_addr_i = AW'($urandom); dc_we_i = 1'($urandom_range(0, 1));
                dc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!ic_rqst_i && !dc_rqst_i) begin
                ic_rqst_i = 1'b1; ic_addr_i = AW'($urandom);
            end
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 6));
            run_txn(lat, $urandom_range(0, 5) == 0, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
